segments_scan_driver: RTL

- Sits directly downstream of the Avalon segments-display PIO and consumes its 21-bit out_port: 3 digits × 7 segments, 1 = lit.
- Time-multiplexes the three digits onto one shared segment bus with per-digit enables.
- Adds an anti-ghosting guard interval and PWM brightness control.
- Captures the PIO value only at frame boundaries, so software writes never tear mid-frame.

---
 rtl/segments_pkg.sv | 23 ++
 rtl/segments_scan_timer.sv | 44 ++++
 rtl/segments_scan_driver.sv | 109 ++++++++++
 3 files changed

// File: rtl/segments_pkg.sv
`default_nettype none
// ============================================================================
// Module   : segments_pkg
// Brief    : Shared constants and types for the 3-digit 7-segment scan path.
// Revision : 1.0 - initial release
// ============================================================================
package segments_pkg;

  localparam int NUM_DIGITS     = 3;
  localparam int SEGS_PER_DIGIT = 7;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  typedef logic [SEGS_PER_DIGIT-1:0] digit_pat_t;

endpackage
`default_nettype wire

// File: rtl/segments_scan_timer.sv
`default_nettype none
// ============================================================================
// Module   : segments_scan_timer
// Brief    : Slot tick counter and active-digit index; flags the last cycle of
//            each frame.
// Revision : 1.0 - initial release
// ============================================================================
module segments_scan_timer #(
  parameter int DIGIT_PERIOD_CYCLES = 50000,
  parameter int NUM_DIGITS          = 3,
  parameter int TICK_W              = 16,
  parameter int IDX_W               = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [TICK_W-1:0] o_tick_cnt,
  output logic [IDX_W-1:0]  o_digit_idx,
  output logic              o_frame_end
);

  localparam logic [TICK_W-1:0] c_tick_last = TICK_W'(DIGIT_PERIOD_CYCLES - 1);
  localparam logic [IDX_W-1:0]  c_idx_last  = IDX_W'(NUM_DIGITS - 1);

  logic [TICK_W-1:0] r_tick_cnt;
  logic [IDX_W-1:0]  r_digit_idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tick_cnt  <= '0;
      r_digit_idx <= '0;
    end else if (r_tick_cnt == c_tick_last) begin
      r_tick_cnt  <= '0;
      r_digit_idx <= (r_digit_idx == c_idx_last) ? '0 : r_digit_idx + 1'b1;
    end else begin
      r_tick_cnt  <= r_tick_cnt + 1'b1;
    end
  end

  assign o_tick_cnt  = r_tick_cnt;
  assign o_digit_idx = r_digit_idx;
  assign o_frame_end = (r_tick_cnt == c_tick_last) && (r_digit_idx == c_idx_last);

endmodule
`default_nettype wire

// File: rtl/segments_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : segments_scan_driver
// Brief    : Multiplexes the PIO digit patterns onto a shared segment bus with
//            guard interval, PWM dimming and frame-aligned snapshotting.
// Revision : 1.0 - initial release
// ============================================================================
module segments_scan_driver #(
  parameter int NUM_DIGITS          = segments_pkg::NUM_DIGITS,
  parameter int SEGS_PER_DIGIT      = segments_pkg::SEGS_PER_DIGIT,
  parameter int DIGIT_PERIOD_CYCLES = 50000,
  parameter int GUARD_CYCLES        = 16,
  parameter int PWM_BITS            = 4,
  parameter bit SEG_ACTIVE_LOW      = 1'b1,
  parameter bit DIG_ACTIVE_LOW      = 1'b1
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [NUM_DIGITS*SEGS_PER_DIGIT-1:0] in_segments,
  input  logic [PWM_BITS-1:0]                  brightness,
  input  logic                                 blank,
  output logic [SEGS_PER_DIGIT-1:0]            seg_n,
  output logic [NUM_DIGITS-1:0]                dig_n,
  output logic                                 frame_start
);

  import segments_pkg::*;

  localparam int c_tick_w = (DIGIT_PERIOD_CYCLES > 1) ? $clog2(DIGIT_PERIOD_CYCLES) : 1;
  localparam int c_idx_w  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int c_bus_w  = NUM_DIGITS * SEGS_PER_DIGIT;

  localparam logic [c_tick_w-1:0]       c_guard    = c_tick_w'(GUARD_CYCLES);
  localparam logic [SEGS_PER_DIGIT-1:0] c_seg_idle = {SEGS_PER_DIGIT{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0]     c_dig_idle = {NUM_DIGITS{DIG_ACTIVE_LOW}};

  logic [c_tick_w-1:0]       w_tick_cnt;
  logic [c_idx_w-1:0]        w_digit_idx;
  logic                      w_frame_end;
  logic [PWM_BITS-1:0]       w_tick_lsb;
  logic                      w_pwm_ok;
  logic                      w_on;
  logic [SEGS_PER_DIGIT-1:0] w_seg_on;
  logic [NUM_DIGITS-1:0]     w_dig_on;

  logic [c_bus_w-1:0]        r_shadow_seg;
  logic [PWM_BITS-1:0]       r_shadow_bri;
  logic                      r_frame_end_d;

  segments_scan_timer #(
    .DIGIT_PERIOD_CYCLES (DIGIT_PERIOD_CYCLES),
    .NUM_DIGITS          (NUM_DIGITS),
    .TICK_W              (c_tick_w),
    .IDX_W               (c_idx_w)
  ) u_timer (
    .clk         (clk),
    .reset_n     (reset_n),
    .o_tick_cnt  (w_tick_cnt),
    .o_digit_idx (w_digit_idx),
    .o_frame_end (w_frame_end)
  );

  // Frame-aligned capture keeps software writes from tearing a frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow_seg  <= '0;
      r_shadow_bri  <= '0;
      r_frame_end_d <= 1'b0;
    end else begin
      r_frame_end_d <= w_frame_end;
      if (w_frame_end) begin
        r_shadow_seg <= in_segments;
        r_shadow_bri <= brightness;
      end
    end
  end

  assign w_tick_lsb = PWM_BITS'(w_tick_cnt);
  assign w_pwm_ok   = (r_shadow_bri == '1) || (w_tick_lsb < r_shadow_bri);
  assign w_on       = !blank && (w_tick_cnt >= c_guard) && w_pwm_ok;

  always_comb begin
    w_seg_on = '0;
    w_dig_on = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (w_digit_idx == c_idx_w'(d)) begin
        w_dig_on[d] = w_on;
        if (w_on) begin
          w_seg_on = r_shadow_seg[d*SEGS_PER_DIGIT +: SEGS_PER_DIGIT];
        end
      end
    end
  end

  // XOR with the idle level applies the pin polarity.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_n       <= c_seg_idle;
      dig_n       <= c_dig_idle;
      frame_start <= 1'b0;
    end else begin
      seg_n       <= w_seg_on ^ c_seg_idle;
      dig_n       <= w_dig_on ^ c_dig_idle;
      frame_start <= r_frame_end_d;
    end
  end

endmodule
`default_nettype wire
